// File: rtl/tdm_mux_8x1.sv
// Purpose: captures a parallel frame of 2^SEL_SIZE bits and serializes it one channel per slot, tagging each slot with its channel index.
// Latency: slot 0 appears the cycle after acceptance; a frame occupies N*SLOT_CYCLES cycles, and back-to-back frames run with no gap.
// Backpressure: load_ready is high in IDLE and in the final cycle of a frame only; flush forces it low and aborts the frame.
module tdm_mux_8x1 #(
    parameter int SEL_SIZE    = 3,
    parameter int SLOT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(1<<SEL_SIZE)-1:0]  din,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      flush,
    output logic                      dout,
    output logic [SEL_SIZE-1:0]       sel_out,
    output logic                      dout_valid,
    output logic                      frame_start,
    output logic                      busy
);

    localparam int N  = 1 << SEL_SIZE;
    // Narrowest counter that still holds SLOT_CYCLES-1, never below one bit.
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [CW-1:0]       CYC_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [SEL_SIZE-1:0] SLOT_LAST = {SEL_SIZE{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [N-1:0]        frame_reg;
    logic [SEL_SIZE-1:0] slot;
    logic [CW-1:0]       cyc;

    logic cyc_end;
    logic frame_end;
    logic accept;

    // Slot/frame boundary decodes shared by the counters and the FSM.
    assign cyc_end   = (cyc == CYC_LAST);
    assign frame_end = (state == SHIFT) && (slot == SLOT_LAST) && cyc_end;
    assign accept    = load_valid && load_ready;

    // State register; reset drops straight back to IDLE so no partial frame survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush beats everything, then a new frame, then end-of-frame drop to IDLE.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = SHIFT;
        end else if (frame_end) begin
            state_nxt = IDLE;
        end
    end

    // Frame capture and slot/cycle counters; counters clear whenever the frame ends or is aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            slot      <= '0;
            cyc       <= '0;
        end else if (flush) begin
            slot <= '0;
            cyc  <= '0;
        end else if (accept) begin
            frame_reg <= din;
            slot      <= '0;
            cyc       <= '0;
        end else if (state == SHIFT) begin
            if (frame_end) begin
                slot <= '0;
                cyc  <= '0;
            end else if (cyc_end) begin
                slot <= slot + 1'b1;
                cyc  <= '0;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    // Outputs decode state and counters only; load_ready additionally sees flush.
    always_comb begin
        load_ready  = 1'b0;
        dout        = 1'b0;
        sel_out     = '0;
        dout_valid  = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                load_ready = !flush;
            end
            SHIFT: begin
                load_ready  = !flush && (slot == SLOT_LAST) && cyc_end;
                busy        = 1'b1;
                dout_valid  = 1'b1;
                sel_out     = slot;
                dout        = frame_reg[slot];
                frame_start = (slot == '0) && (cyc == '0);
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Directed bench for tdm_mux_8x1: one instance with single-cycle slots and one with three-cycle slots.
// Inputs are driven 1 ns after the rising edge and outputs are checked 1 ns later.
// Expected values come from hand-derived frame bit patterns.
module tb_tdm_mux_8x1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] din = '0;
    logic       load_valid = 1'b0;
    logic       flush = 1'b0;
    logic       load_ready, dout, dout_valid, frame_start, busy;
    logic [2:0] sel_out;

    logic [7:0] din3 = '0;
    logic       load_valid3 = 1'b0;
    logic       flush3 = 1'b0;
    logic       load_ready3, dout3, dout_valid3, frame_start3, busy3;
    logic [2:0] sel_out3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdm_mux_8x1 #(.SEL_SIZE(3), .SLOT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .flush(flush), .dout(dout), .sel_out(sel_out),
        .dout_valid(dout_valid), .frame_start(frame_start), .busy(busy)
    );

    tdm_mux_8x1 #(.SEL_SIZE(3), .SLOT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .load_valid(load_valid3),
        .load_ready(load_ready3), .flush(flush3), .dout(dout3), .sel_out(sel_out3),
        .dout_valid(dout_valid3), .frame_start(frame_start3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, ".dout_valid"}, dout_valid, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".dout"}, dout, 1'b0);
        chk({tag, ".sel_out"}, sel_out, 3'd0);
        chk({tag, ".frame_start"}, frame_start, 1'b0);
        chk({tag, ".load_ready"}, load_ready, exp_ready);
    endtask

    // Walks all 8 slots of frame f; din is scrambled during the frame, and in the
    // last slot load_valid/din present the follow-on request (lv_last, nxt).
    task automatic run_frame(input string tag, input logic [7:0] f,
                             input logic lv_all, input logic lv_last, input logic [7:0] nxt);
        for (int k = 0; k < 8; k++) begin
            din        = (k == 7) ? nxt : ~f;
            load_valid = (k == 7) ? lv_last : lv_all;
            #1;
            chk($sformatf("%s.sel%0d", tag, k), sel_out, k[2:0]);
            chk($sformatf("%s.dout%0d", tag, k), dout, f[k]);
            chk($sformatf("%s.vld%0d", tag, k), dout_valid, 1'b1);
            chk($sformatf("%s.busy%0d", tag, k), busy, 1'b1);
            chk($sformatf("%s.fs%0d", tag, k), frame_start, (k == 0));
            chk($sformatf("%s.rdy%0d", tag, k), load_ready, (k == 7));
            tick();
        end
    endtask

    initial begin
        // Reset state
        #3;
        chk_idle("reset", 1'b1);
        chk("reset.dout_valid3", dout_valid3, 1'b0);
        chk("reset.load_ready3", load_ready3, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame 8'b1011_0010
        din = 8'hB2; load_valid = 1'b1;
        #1;
        chk("basic.accept_rdy", load_ready, 1'b1);
        tick();
        run_frame("basic", 8'hB2, 1'b0, 1'b0, 8'h00);
        load_valid = 1'b0;
        #1;
        chk_idle("basic.after", 1'b1);
        tick();

        // Back-to-back A5 then FF with load_valid held
        din = 8'hA5; load_valid = 1'b1;
        tick();
        run_frame("b2b_a5", 8'hA5, 1'b1, 1'b1, 8'hFF);
        run_frame("b2b_ff", 8'hFF, 1'b1, 1'b0, 8'h00);
        load_valid = 1'b0;
        #1;
        chk_idle("b2b.after", 1'b1);
        tick();

        // din stability: 0F accepted, din shows F0 throughout the frame
        din = 8'h0F; load_valid = 1'b1;
        tick();
        run_frame("stable", 8'h0F, 1'b0, 1'b0, 8'hF0);
        load_valid = 1'b0;
        tick();

        // Flush at slot 3 with a simultaneous load request
        din = 8'h3C; load_valid = 1'b1;
        tick();
        load_valid = 1'b0; din = 8'h00;
        tick(); tick(); tick();
        flush = 1'b1; load_valid = 1'b1; din = 8'hFF;
        #1;
        chk("flush.sel3", sel_out, 3'd3);
        chk("flush.dout3", dout, 1'b1);
        chk("flush.rdy_forced", load_ready, 1'b0);
        tick();
        flush = 1'b0; load_valid = 1'b0;
        #1;
        chk_idle("flush.after", 1'b1);
        tick();
        chk_idle("flush.after2", 1'b1);

        // flush in IDLE only holds load_ready low
        flush = 1'b1;
        #1;
        chk("flush_idle.rdy", load_ready, 1'b0);
        chk("flush_idle.vld", dout_valid, 1'b0);
        tick();
        flush = 1'b0;
        tick();

        // Async reset mid-frame at slot 5
        din = 8'hE7; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("arst.sel5", sel_out, 3'd5);
        chk("arst.dout5", dout, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst.during", 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("arst.after1", 1'b1);
        tick();
        chk_idle("arst.after2", 1'b1);

        // SLOT_CYCLES=3 instance with 8'b1000_0001
        din3 = 8'h81; load_valid3 = 1'b1;
        #1;
        chk("s3.accept_rdy", load_ready3, 1'b1);
        tick();
        load_valid3 = 1'b0; din3 = 8'h7E;
        for (int i = 0; i < 24; i++) begin
            #1;
            chk($sformatf("s3.sel%0d", i), sel_out3, 32'(i / 3));
            chk($sformatf("s3.dout%0d", i), dout3, ((i / 3) == 0) || ((i / 3) == 7));
            chk($sformatf("s3.vld%0d", i), dout_valid3, 1'b1);
            chk($sformatf("s3.fs%0d", i), frame_start3, (i == 0));
            chk($sformatf("s3.rdy%0d", i), load_ready3, (i == 23));
            tick();
        end
        #1;
        chk("s3.after.vld", dout_valid3, 1'b0);
        chk("s3.after.busy", busy3, 1'b0);
        chk("s3.after.rdy", load_ready3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
